mult_div: RTL and testbench



---
 rtl/mult_div_pkg.sv | 25 ++
 rtl/mult_div_addsub.sv | 18 +
 rtl/mult_div.sv | 179 +++++++++++++++++
 tb/tb_mult_div.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Pure declarations: no latency, no flow control.
package mult_div_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int LATENCY    = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // INT_MIN maps to 0x80000000, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag32(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_addsub.sv
// 33-bit adder/subtractor shared by the Booth and shift/subtract steps.
// Combinational (0 cycles); no flow control.
module mult_div_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [33:0] full;

    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
    assign sum  = full[32:0];
    // For subtraction, cout = 1 means no borrow (a >= b unsigned).
    assign cout = full[33];

endmodule

// File: rtl/mult_div.sv
// Signed 32-bit Booth multiply / restoring divide; 33 cycles start-to-ready, any start aborts and restarts.
// Define MULTDIV_DIV_OVF_EN to flag INT_MIN / -1 as an exception.
module mult_div
    import mult_div_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

`ifdef MULTDIV_DIV_OVF_EN
    localparam logic DIV_OVF_EXC = 1'b1;
`else
    localparam logic DIV_OVF_EXC = 1'b0;
`endif

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] acc_q, acc_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opb_q, opb_d;
    logic        bit_q, bit_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic [32:0] add_a, add_b, add_sum;
    logic        add_sub, add_cout;
    logic [32:0] div_rem;
    logic [32:0] booth_acc;
    logic [33:0] prod_hi;

    // Mult: {acc, lo, bit} is the Booth product register, opb the multiplicand.
    // Div:  acc is the partial remainder, lo shifts dividend out / quotient in.
    assign div_rem = {acc_q[31:0], lo_q[31]};

    always_comb begin
        add_a   = acc_q;
        add_b   = {opb_q[31], opb_q};
        add_sub = lo_q[0] & ~bit_q;
        if (op_q == OP_DIV) begin
            add_a   = div_rem;
            add_b   = {1'b0, opb_q};
            add_sub = 1'b1;
        end
    end

    mult_div_addsub u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign booth_acc = (lo_q[0] ^ bit_q) ? add_sum : acc_q;
    assign prod_hi   = {acc_q, lo_q[31]};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        bit_d   = bit_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;

        if (ctrl_MULT || ctrl_DIV) begin
            state_d = RUN;
            cnt_d   = 5'd0;
            acc_d   = 33'd0;
            bit_d   = 1'b0;
            if (ctrl_MULT) begin
                op_d  = OP_MULT;
                lo_d  = data_operandB;
                opb_d = data_operandA;
                neg_d = 1'b0;
                dz_d  = 1'b0;
                ovf_d = 1'b0;
            end else begin
                op_d  = OP_DIV;
                lo_d  = mag32(data_operandA);
                opb_d = mag32(data_operandB);
                neg_d = data_operandA[31] ^ data_operandB[31];
                dz_d  = (data_operandB == 32'd0);
                ovf_d = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (op_q == OP_MULT) begin
                        acc_d = {booth_acc[32], booth_acc[32:1]};
                        lo_d  = {booth_acc[0], lo_q[31:1]};
                        bit_d = lo_q[0];
                    end else begin
                        acc_d = add_cout ? add_sum : div_rem;
                        lo_d  = {lo_q[30:0], add_cout};
                    end
                    if (cnt_q == 5'(ITERATIONS - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                    rdy_d   = 1'b1;
                    if (op_q == OP_MULT) begin
                        res_d = lo_q;
                        exc_d = ~((&prod_hi) | ~(|prod_hi));
                    end else if (dz_q) begin
                        res_d = 32'd0;
                        exc_d = 1'b1;
                    end else begin
                        res_d = neg_q ? (~lo_q + 32'd1) : lo_q;
                        exc_d = ovf_q & DIV_OVF_EXC;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= 5'd0;
            acc_q   <= 33'd0;
            lo_q    <= 32'd0;
            opb_q   <= 32'd0;
            bit_q   <= 1'b0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= 32'd0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            bit_q   <= bit_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_div.sv
// Bench for mult_div: vector table, randomized ops against an arithmetic model, abort/reset sequences.
module tb_mult_div;
    import mult_div_pkg::*;

`ifdef MULTDIV_DIV_OVF_EN
    localparam logic OVF_EXC = 1'b1;
`else
    localparam logic OVF_EXC = 1'b0;
`endif

    logic        clock;
    logic        resetn;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    int n_cmp;
    int n_err;

    mult_div dut (
        .clock          (clock),
        .resetn         (resetn),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_exc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact 64-bit arithmetic, C-style truncating division.
    task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
        longint p;
        if (!is_div) begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            r = p[31:0];
            e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = OVF_EXC;
        end else begin
            p = longint'(signed'(a)) / longint'(signed'(b));
            r = p[31:0];
            e = 1'b0;
        end
    endtask

    // Starts an op (ctrl held for 'hold' edges), then watches 40 edges for ready.
    // lat counts edges from the first start edge; operands are scrambled after the start.
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res, output logic exc,
                         output int lat, output int nrdy);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = m;
        ctrl_DIV  = d;
        for (int h = 0; h < hold; h++) @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        res = 32'd0;
        exc = 1'b0;
        lat = -1;
        nrdy = 0;
        for (int i = hold; i < hold + 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                nrdy++;
                if (lat < 0) begin
                    lat = i;
                    res = data_result;
                    exc = data_exception;
                end
            end
        end
    endtask

    task automatic check_op(input string name, input logic is_div, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic ee);
        logic [31:0] res;
        logic        exc;
        int          lat, nrdy;
        do_op(!is_div, is_div, a, b, 1, res, exc, lat, nrdy);
        chk({name, " latency"}, 64'(lat), 64'(LATENCY));
        chk({name, " ready count"}, 64'(nrdy), 64'd1);
        chk({name, " result"}, 64'(res), 64'(er));
        chk({name, " exception"}, 64'(exc), 64'(ee));
        chk({name, " result held"}, 64'(data_result), 64'(er));
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] r, res;
        logic        e, exc;
        int          lat, nrdy;
        logic [31:0] edge_vals[6];

        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;

        vecs.push_back('{"mul 3*-4",        1'b0, 32'd3,          32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0});
        vecs.push_back('{"mul 65536^2",     1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"mul min*1",       1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0});
        vecs.push_back('{"mul min*-1",      1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"mul -1*-1",       1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0});
        vecs.push_back('{"div -7/2",        1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"div 100/-10",     1'b1, 32'd100,        32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0});
        vecs.push_back('{"div 5/0",         1'b1, 32'd5,          32'd0,         32'd0,         1'b1});
        vecs.push_back('{"div min/-1",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, OVF_EXC});
        vecs.push_back('{"div max/1",       1'b1, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0});
        vecs.push_back('{"div min/2",       1'b1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0});

        #12;
        chk("reset result", 64'(data_result), 64'd0);
        chk("reset exception", 64'(data_exception), 64'd0);
        chk("reset ready", 64'(data_resultRDY), 64'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        @(posedge clock);
        #1;

        foreach (vecs[i])
            check_op(vecs[i].name, vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_exc);

        // Randomized ops, with operands biased toward boundary values some of the time.
        edge_vals = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_0000};
        for (int k = 0; k < 40; k++) begin
            logic        d;
            logic [31:0] a, b;
            d = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = edge_vals[$urandom_range(0, 5)];
                1:       b = 32'($signed($urandom_range(0, 200)) - 100);
                default: b = $urandom;
            endcase
            model(d, a, b, r, e);
            check_op($sformatf("rand%0d", k), d, a, b, r, e);
        end

        // Both ctrl bits high: multiply takes priority.
        do_op(1'b1, 1'b1, 32'd6, 32'd3, 1, res, exc, lat, nrdy);
        chk("both-start result", 64'(res), 64'd18);
        chk("both-start latency", 64'(lat), 64'(LATENCY));

        // Ctrl held three cycles: each cycle restarts, ready 33 after the last.
        do_op(1'b0, 1'b1, 32'd20, 32'd4, 3, res, exc, lat, nrdy);
        chk("retrigger latency", 64'(lat), 64'(LATENCY + 2));
        chk("retrigger ready count", 64'(nrdy), 64'd1);
        chk("retrigger result", 64'(res), 64'd5);

        // Abort: mult 1000*1000 then div 9/3 five cycles later.
        data_operandA = 32'd1000;
        data_operandB = 32'd1000;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1 ctrl_MULT = 1'b0;
        nrdy = 0;
        for (int i = 1; i < 5; i++) begin
            @(posedge clock);
            #1 if (data_resultRDY) nrdy++;
        end
        do_op(1'b0, 1'b1, 32'd9, 32'd3, 1, res, exc, lat, nrdy);
        chk("abort latency", 64'(lat), 64'(LATENCY));
        chk("abort ready count", 64'(nrdy), 64'd1);
        chk("abort result", 64'(res), 64'd3);
        chk("abort exception", 64'(exc), 64'd0);

        // Reset ten cycles into a divide; previous result (3) must clear at once.
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
        repeat (10) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        chk("midreset result", 64'(data_result), 64'd0);
        chk("midreset exception", 64'(data_exception), 64'd0);
        chk("midreset ready", 64'(data_resultRDY), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clock);
            #1 if (data_resultRDY) nrdy++;
        end
        chk("post-reset ready count", 64'(nrdy), 64'd0);
        chk("post-reset result", 64'(data_result), 64'd0);

        check_op("after reset div 84/-4", 1'b1, 32'd84, 32'hFFFF_FFFC, 32'hFFFF_FFEB, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
